// File: rtl/cnn_relu_maxpool.sv
// cnn_relu_maxpool
// Streaming activation plus 2x2 / stride-2 max pooling over a raster-ordered
// feature map. A half-row line buffer holds the horizontal pair maxima of each
// even row. Those maxima are combined with the matching pair on the following
// odd row to produce one pooled value per window.
//
// Build option: define RELU_EN to clamp negative samples to zero before
// pooling. Without it, pooling is a plain signed max.
//
// Output protocol: OutValid is a one-cycle strobe that qualifies OutData and
// OutLast. There is no ready signal, so the consumer must take every strobe.
// Input samples are accepted on every cycle where InValid is high.
module cnn_relu_maxpool #(
    parameter int DATAWIDTH = 22,
    parameter int COLS      = 4,
    parameter int ROWS      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        Start,
    input  logic                        InValid,
    input  logic signed [DATAWIDTH-1:0] InData,
    output logic                        OutValid,
    output logic signed [DATAWIDTH-1:0] OutData,
    output logic                        OutLast
);

    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LBN = COLS / 2;
    localparam int LIW = (LBN > 1) ? $clog2(LBN) : 1;

    logic        [CW-1:0]        r_col;
    logic        [RW-1:0]        r_row;
    logic signed [DATAWIDTH-1:0] r_h;
    logic signed [DATAWIDTH-1:0] r_lb [LBN];
    logic                        r_out_valid;
    logic signed [DATAWIDTH-1:0] r_out_data;
    logic                        r_out_last;

    logic        [CW-1:0]        w_col;
    logic        [RW-1:0]        w_row;
    logic        [LIW-1:0]       w_lb_idx;
    logic signed [DATAWIDTH-1:0] w_x;
    logic signed [DATAWIDTH-1:0] w_pair_max;
    logic signed [DATAWIDTH-1:0] w_pool;
    logic                        w_last;

    function automatic logic signed [DATAWIDTH-1:0] f_max(
        input logic signed [DATAWIDTH-1:0] a,
        input logic signed [DATAWIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Start forces the incoming sample to position (0,0).
    assign w_col    = Start ? '0 : r_col;
    assign w_row    = Start ? '0 : r_row;
    assign w_lb_idx = LIW'(w_col >> 1);
    assign w_last   = (w_row == RW'(ROWS - 1)) && (w_col == CW'(COLS - 1));

`ifdef RELU_EN
    assign w_x = InData[DATAWIDTH-1] ? '0 : InData;
`else
    assign w_x = InData;
`endif

    assign w_pair_max = f_max(r_h, w_x);
    assign w_pool     = f_max(r_lb[w_lb_idx], w_pair_max);

    // Position counters, pair register, line buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_h         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            for (int i = 0; i < LBN; i++) begin
                r_lb[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (Start) begin
                r_col <= '0;
                r_row <= '0;
                r_h   <= '0;
            end
            if (InValid) begin
                if (w_col == CW'(COLS - 1)) begin
                    r_col <= '0;
                    r_row <= (w_row == RW'(ROWS - 1)) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                end

                if (!w_col[0]) begin
                    r_h <= w_x;
                end else if (!w_row[0]) begin
                    r_lb[w_lb_idx] <= w_pair_max;
                end else begin
                    r_out_data  <= w_pool;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_last;
                end
            end
        end
    end

    assign OutValid = r_out_valid;
    assign OutData  = r_out_data;
    assign OutLast  = r_out_last;

endmodule

// File: tb/tb_cnn_relu_maxpool.sv
// tb_cnn_relu_maxpool
// Directed and randomized frames checked against a frame-array model that
// computes each pooled value directly from the four window samples.
// Build option RELU_EN selects the clamped expectation.
module tb_cnn_relu_maxpool;

    localparam int DW = 22;
    localparam int NC = 4;
    localparam int NR = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 out_last;

    int n_cmp  = 0;
    int n_fail = 0;

    logic signed [DW-1:0] exp_q [$];
    logic signed [DW-1:0] m_frame [NR][NC];
    int                   m_r;
    int                   m_c;

    logic signed [DW-1:0] minv;
    logic signed [DW-1:0] maxv;

    cnn_relu_maxpool #(
        .DATAWIDTH(DW),
        .COLS     (NC),
        .ROWS     (NR)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Start   (start),
        .InValid (in_valid),
        .InData  (in_data),
        .OutValid(out_valid),
        .OutData (out_data),
        .OutLast (out_last)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic signed [DW-1:0] act(input logic signed [DW-1:0] d);
`ifdef RELU_EN
        return (d < 0) ? '0 : d;
`else
        return d;
`endif
    endfunction

    // Reference model: store activated samples in a full frame array and, when a
    // window's bottom-right sample arrives, push the max of its four samples.
    task automatic model_step(input logic r, input logic s, input logic v,
                              input logic signed [DW-1:0] d,
                              output logic ev, output logic el);
        logic signed [DW-1:0] m;
        ev = 1'b0;
        el = 1'b0;
        if (r) begin
            m_r = 0;
            m_c = 0;
            exp_q.delete();
            return;
        end
        if (s) begin
            m_r = 0;
            m_c = 0;
        end
        if (v) begin
            m_frame[m_r][m_c] = act(d);
            if ((m_r % 2 == 1) && (m_c % 2 == 1)) begin
                m = m_frame[m_r][m_c];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (m_frame[m_r-dr][m_c-dc] > m) m = m_frame[m_r-dr][m_c-dc];
                exp_q.push_back(m);
                ev = 1'b1;
                el = (m_r == NR - 1) && (m_c == NC - 1);
            end
            m_c++;
            if (m_c == NC) begin
                m_c = 0;
                m_r = (m_r + 1) % NR;
            end
        end
    endtask

    // driver: apply inputs at negedge, capture outputs just after the next posedge
    task automatic drive(input logic r, input logic s, input logic v,
                         input logic signed [DW-1:0] d,
                         output logic ov, output logic signed [DW-1:0] od,
                         output logic ol);
        @(negedge clk);
        rst_n    = r;
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        ov = out_valid;
        od = out_data;
        ol = out_last;
    endtask

    task automatic test_reset();
        logic ov, ol, ev, el;
        logic signed [DW-1:0] od;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) m_frame[r][c] = '0;
        repeat (2) begin
            drive(1'b1, 1'b0, 1'b1, DW'(123), ov, od, ol);
            model_step(1'b1, 1'b0, 1'b1, DW'(123), ev, el);
        end
        n_cmp++;
        if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ov); end
        n_cmp++;
        if (od !== '0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", od); end
        n_cmp++;
        if (ol !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", ol); end
    endtask

    task automatic test_basic();
        logic ov, ol, ev, el;
        logic signed [DW-1:0] od, e;
        logic signed [DW-1:0] got [$];
        int want [4] = '{6, 8, 14, 16};
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, i == 1, 1'b1, DW'(i), ov, od, ol);
            model_step(1'b0, i == 1, 1'b1, DW'(i), ev, el);
            n_cmp++;
            if (ov !== ev || ol !== el) begin
                n_fail++;
                $display("FAIL basic_strobe sample %0d: got v=%b l=%b want v=%b l=%b", i, ov, ol, ev, el);
            end
            if (ev) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (od !== e) begin n_fail++; $display("FAIL basic_data sample %0d: got %0d want %0d", i, od, e); end
            end
            if (ov === 1'b1) got.push_back(od);
        end
        n_cmp++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d outputs want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++)
                if (got[k] !== DW'(want[k])) begin
                    n_fail++;
                    $display("FAIL basic_const %0d: got %0d want %0d", k, got[k], want[k]);
                end
        end
    endtask

    task automatic test_negatives();
        logic ov, ol, ev, el;
        logic signed [DW-1:0] od, e, want;
`ifdef RELU_EN
        want = '0;
`else
        want = -DW'(5);
`endif
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, i == 0, 1'b1, -DW'(5), ov, od, ol);
            model_step(1'b0, i == 0, 1'b1, -DW'(5), ev, el);
            n_cmp++;
            if (ov !== ev || ol !== el) begin
                n_fail++;
                $display("FAIL neg_strobe sample %0d: got v=%b l=%b want v=%b l=%b", i, ov, ol, ev, el);
            end
            if (ev) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (od !== e || od !== want) begin
                    n_fail++;
                    $display("FAIL neg_data sample %0d: got %0d want %0d", i, od, want);
                end
            end
        end
    endtask

    task automatic test_extremes();
        logic ov, ol, ev, el;
        logic signed [DW-1:0] od, e, d, want_min;
        logic signed [DW-1:0] got [$];
`ifdef RELU_EN
        want_min = '0;
`else
        want_min = minv;
`endif
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                if (f == 1) d = minv;
                else if (i == 0) d = minv;
                else if (i == 1) d = maxv;
                else if (i == 4) d = '0;
                else if (i == 5) d = -DW'(1);
                else d = DW'($urandom);
                drive(1'b0, i == 0, 1'b1, d, ov, od, ol);
                model_step(1'b0, i == 0, 1'b1, d, ev, el);
                n_cmp++;
                if (ov !== ev || ol !== el) begin
                    n_fail++;
                    $display("FAIL ext_strobe f%0d sample %0d: got v=%b l=%b want v=%b l=%b", f, i, ov, ol, ev, el);
                end
                if (ev) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (od !== e) begin n_fail++; $display("FAIL ext_data f%0d sample %0d: got %0d want %0d", f, i, od, e); end
                end
                if (ov === 1'b1) got.push_back(od);
            end
        end
        n_cmp++;
        if (got.size() != 8) begin
            n_fail++;
            $display("FAIL ext_count: got %0d outputs want 8", got.size());
        end else begin
            if (got[0] !== maxv) begin n_fail++; $display("FAIL ext_mixed: got %0d want %0d", got[0], maxv); end
            for (int k = 4; k < 8; k++)
                if (got[k] !== want_min) begin
                    n_fail++;
                    $display("FAIL ext_allmin %0d: got %0d want %0d", k, got[k], want_min);
                end
        end
    endtask

    task automatic test_gapped();
        logic ov, ol, ev, el, v;
        logic signed [DW-1:0] od, e, d;
        logic signed [DW-1:0] got [$];
        int want [4] = '{6, 8, 14, 16};
        int idles;
        for (int f = 0; f < 2; f++) begin
            for (int i = 1; i <= 16; i++) begin
                idles = $urandom_range(0, 3);
                d = (f == 0) ? DW'(i) : DW'($urandom);
                for (int g = 0; g <= idles; g++) begin
                    v = (g == idles);
                    drive(1'b0, (f == 0) && (i == 1) && v, v, v ? d : DW'($urandom), ov, od, ol);
                    model_step(1'b0, (f == 0) && (i == 1) && v, v, d, ev, el);
                    n_cmp++;
                    if (ov !== ev || ol !== el) begin
                        n_fail++;
                        $display("FAIL gap_strobe f%0d sample %0d gap %0d: got v=%b l=%b want v=%b l=%b", f, i, g, ov, ol, ev, el);
                    end
                    if (ev) begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (od !== e) begin n_fail++; $display("FAIL gap_data f%0d sample %0d: got %0d want %0d", f, i, od, e); end
                    end
                    if (ov === 1'b1 && f == 0) got.push_back(od);
                end
            end
        end
        n_cmp++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL gap_count: got %0d outputs want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++)
                if (got[k] !== DW'(want[k])) begin
                    n_fail++;
                    $display("FAIL gap_const %0d: got %0d want %0d", k, got[k], want[k]);
                end
        end
    endtask

    task automatic test_start_mid();
        logic ov, ol, ev, el, s;
        logic signed [DW-1:0] od, e, d;
        logic signed [DW-1:0] got [$];
        int want [4] = '{6, 8, 14, 16};
        int nlast = 0;
        for (int j = 0; j < 23; j++) begin
            s = (j == 0) || (j == 7);
            d = (j < 7) ? DW'(j + 1) : DW'(j - 6);
            drive(1'b0, s, 1'b1, d, ov, od, ol);
            model_step(1'b0, s, 1'b1, d, ev, el);
            n_cmp++;
            if (ov !== ev || ol !== el) begin
                n_fail++;
                $display("FAIL start_strobe step %0d: got v=%b l=%b want v=%b l=%b", j, ov, ol, ev, el);
            end
            if (ev) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (od !== e) begin n_fail++; $display("FAIL start_data step %0d: got %0d want %0d", j, od, e); end
            end
            if (ov === 1'b1 && j >= 7) got.push_back(od);
            if (ol === 1'b1) nlast++;
        end
        n_cmp++;
        if (got.size() != 4 || nlast != 1) begin
            n_fail++;
            $display("FAIL start_count: got %0d outputs %0d last want 4 outputs 1 last", got.size(), nlast);
        end else begin
            for (int k = 0; k < 4; k++)
                if (got[k] !== DW'(want[k])) begin
                    n_fail++;
                    $display("FAIL start_const %0d: got %0d want %0d", k, got[k], want[k]);
                end
        end
    endtask

    task automatic test_reset_mid();
        logic ov, ol, ev, el;
        logic signed [DW-1:0] od, e;
        logic signed [DW-1:0] got [$];
        int want [4] = '{6, 8, 14, 16};
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, i == 1, 1'b1, DW'(i), ov, od, ol);
            model_step(1'b0, i == 1, 1'b1, DW'(i), ev, el);
            if (ev) void'(exp_q.pop_front());
        end
        drive(1'b1, 1'b1, 1'b1, DW'(11), ov, od, ol);
        model_step(1'b1, 1'b1, 1'b1, DW'(11), ev, el);
        n_cmp++;
        if (ov !== 1'b0 || od !== '0 || ol !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got v=%b d=%0d l=%b want 0 0 0", ov, od, ol);
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, DW'(i), ov, od, ol);
            model_step(1'b0, 1'b0, 1'b1, DW'(i), ev, el);
            n_cmp++;
            if (ov !== ev || ol !== el) begin
                n_fail++;
                $display("FAIL rstmid_strobe sample %0d: got v=%b l=%b want v=%b l=%b", i, ov, ol, ev, el);
            end
            if (ev) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (od !== e) begin n_fail++; $display("FAIL rstmid_data sample %0d: got %0d want %0d", i, od, e); end
            end
            if (ov === 1'b1) got.push_back(od);
        end
        n_cmp++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL rstmid_count: got %0d outputs want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++)
                if (got[k] !== DW'(want[k])) begin
                    n_fail++;
                    $display("FAIL rstmid_const %0d: got %0d want %0d", k, got[k], want[k]);
                end
        end
    endtask

    task automatic test_back_to_back();
        logic ov, ol, ev, el;
        logic signed [DW-1:0] od, e, d;
        for (int i = 0; i < 3 * NR * NC; i++) begin
            d = DW'($urandom);
            drive(1'b0, 1'b0, 1'b1, d, ov, od, ol);
            model_step(1'b0, 1'b0, 1'b1, d, ev, el);
            n_cmp++;
            if (ov !== ev || ol !== el) begin
                n_fail++;
                $display("FAIL b2b_strobe sample %0d: got v=%b l=%b want v=%b l=%b", i, ov, ol, ev, el);
            end
            if (ev) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (od !== e) begin n_fail++; $display("FAIL b2b_data sample %0d: got %0d want %0d", i, od, e); end
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, ov, od, ol);
        n_cmp++;
        if (ov !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got v=%b pending %0d want v=0 pending 0", ov, exp_q.size());
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        minv     = {1'b1, {(DW-1){1'b0}}};
        maxv     = {1'b0, {(DW-1){1'b1}}};
        m_r      = 0;
        m_c      = 0;
        test_reset();
        test_basic();
        test_negatives();
        test_extremes();
        test_gapped();
        test_start_mid();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_relu_maxpool.md
# cnn_relu_maxpool

Streaming ReLU plus 2×2/stride-2 max-pooling stage placed directly downstream of the two-layer convolution block. It consumes the 22-bit signed convolution result stream in raster order, one sample per valid cycle, and emits one pooled value per 2×2 window. It keeps a half-row line buffer of partial maxima and needs no frame memory.

## Interface
- DATAWIDTH, 22: sample width, signed; matches the layer-2 ConvResult width.
- COLS, 4: feature-map width in samples; must be even and ≥2.
- ROWS, 4: feature-map height in rows; must be even and ≥2.
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-high reset; asserted = 1.
- Start  input  1  single-cycle pulse that begins a new frame and clears the position counters.
- InValid  input  1  InData carries a valid sample this cycle.
- InData  input  DATAWIDTH  signed conv result, raster order (row-major, column fastest).
- OutValid  output  1  OutData valid; one-cycle pulse per pooled window.
- OutData  output  DATAWIDTH  signed pooled value.
- OutLast  output  1  high together with OutValid on the final pooled value of a frame.

## Operation
- Counters: `col` (0..COLS-1) and `row` (0..ROWS-1).
  - Both advance only on InValid.
  - `col` wraps to 0 and increments `row`; `row` wraps to 0 after the last sample.
- Activation: x = (RELU_EN && InData < 0) ? 0 : InData. All comparisons are signed and DATAWIDTH-wide. No width growth and no saturation.
- Horizontal register `h` holds the even-column sample of the current pair.
- Line buffer `lb[0..COLS/2-1]`, DATAWIDTH each, indexed by col>>1.
- Even row (row[0]=0):
  - Even col: h ← x.
  - Odd col: lb[col>>1] ← max(h, x).
  - No output.
- Odd row (row[0]=1):
  - Even col: h ← x.
  - Odd col: OutData ← max(lb[col>>1], h, x); OutValid ← 1.
- OutLast ← 1 when the producing sample is at row=ROWS-1, col=COLS-1.
- Ties: any equal value is acceptable, since the result is identical.
- Idle cycles (InValid=0) between samples are allowed anywhere. State holds and no output is produced.
- No backpressure. The output is never stalled.

## Timing
- Reset values: OutValid=0, OutLast=0, OutData=0; col=0, row=0, h=0; all lb entries cleared to 0.
- Latency: OutValid asserts exactly 1 cycle after the InValid cycle carrying the bottom-right sample of a window. It is a one-cycle pulse.
- Throughput: one sample per cycle sustained. Maximum output rate is one per 2 cycles, on odd rows only.
- Start:
  - Clears col, row and h in the same cycle and has priority over counter advance.
  - If Start and InValid are both high, that sample is processed as position (0,0).
  - An OutValid already registered still appears on the next cycle.
  - The lb contents are not cleared, because every entry is rewritten on the even row before it is read.
- Start without a preceding reset is legal at any point. Frames back-to-back with no gap are legal without Start, because the counters wrap naturally.
- Reset mid-frame: all state and outputs return to reset values on the next edge. The partial frame is discarded with no output.
- rst_n has priority over Start and InValid.

## Configuration
- RELU_EN defined: negative samples are clamped to 0 before pooling, so OutData is always ≥0.
- RELU_EN undefined: the clamp is removed and pooling is a plain signed max. Negative results pass through unchanged.
- Ports, widths and timing are identical in both builds.

## Test plan
- Basic pooling: COLS=ROWS=4, Start, then 16 consecutive valid samples 1..16 → OutData 6, 8, 14, 16. OutValid occurs 1 cycle after samples 6, 8, 14 and 16. OutLast is high only with 16.
- Negatives: all 16 samples = −5.
  - With RELU_EN → four outputs of 0.
  - Without RELU_EN → four outputs of −5.
- Extremes: one window containing −2^21, 2^21−1, 0 and −1 → output 2^21−1. A window of all −2^21 gives 0 with RELU_EN and −2^21 without it.
- Gapped input: the basic-pooling data with 0–3 idle cycles inserted randomly → same four outputs, each 1 cycle after its final sample, and no spurious OutValid.
- Start mid-frame: feed 7 samples, then Start with InValid=1 carrying sample 1, followed by 2..16 → outputs exactly 6, 8, 14, 16, with OutLast on the last.
- Reset mid-frame: assert rst_n after 10 samples → OutValid/OutData/OutLast are 0 the next cycle. A subsequent full frame of 1..16 yields 6, 8, 14, 16.
